// File: rtl/pid_ctrl_param.sv
// Line-follower PID speed controller.
// Each valid error sample is saturated and split into three terms. P is the scaled error. I is
// a cleared, overflow-holding accumulator. D is the difference from a delayed sample, scaled.
// Two registered stages turn the terms into left/right motor speeds. spd_vld marks the new
// speeds two cycles after the sample's err_vld.
module pid_ctrl_param #(
    parameter int unsigned ERR_W   = 16,
    parameter int unsigned SAT_W   = 11,
    parameter int unsigned ACC_W   = 16,
    parameter int unsigned I_SHIFT = 6,
    parameter int unsigned D_DEPTH = 2,
    parameter int unsigned SPD_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             moving,
    input  logic             line_present,
    input  logic             err_vld,
    input  logic [ERR_W-1:0] error,
    input  logic [SPD_W-1:0] frwrd,
    input  logic [5:0]       p_coeff,
    input  logic [6:0]       d_coeff,
    output logic [SPD_W-1:0] lft_spd,
    output logic [SPD_W-1:0] rght_spd,
    output logic             spd_vld,
    output logic             i_hold
);

    localparam int unsigned P_W    = SAT_W + 4;   // saturated P_term width
    localparam int unsigned PROD_W = SAT_W + 6;   // full err_sat * p_coeff width
    localparam int unsigned DIFF_W = SAT_W + 1;   // derivative difference width
    localparam int unsigned DSAT_W = 8;           // saturated derivative width
    localparam int unsigned D_W    = 15;          // D_term width
    localparam int unsigned I_W    = ACC_W - I_SHIFT;
    localparam int unsigned PID_W  = 17;
    localparam int unsigned SUM_W  = ((SPD_W > PID_W) ? SPD_W : PID_W) + 1;

    // Clamp a speed sum into the signed SPD_W range.
    function automatic logic [SPD_W-1:0] sat_spd(input logic [SUM_W-1:0] v);
        if (v[SUM_W-1:SPD_W-1] == {(SUM_W-SPD_W+1){v[SUM_W-1]}}) begin
            sat_spd = v[SPD_W-1:0];
        end else if (v[SUM_W-1]) begin
            sat_spd = {1'b1, {(SPD_W-1){1'b0}}};
        end else begin
            sat_spd = {1'b0, {(SPD_W-1){1'b1}}};
        end
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             i_hold_q, i_hold_d;
    logic             line_q;
    logic [SAT_W-1:0] hist_q [D_DEPTH];
    logic [SAT_W-1:0] hist_d [D_DEPTH];

    logic             s1_vld_q, s1_vld_d;
    logic [P_W-1:0]   p_term_q, p_term_d;
    logic [I_W-1:0]   i_term_q, i_term_d;
    logic [D_W-1:0]   d_term_q, d_term_d;

    logic [SPD_W-1:0] lft_q, lft_d;
    logic [SPD_W-1:0] rght_q, rght_d;
    logic             spd_vld_q, spd_vld_d;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [SAT_W-1:0]  err_sat;
    logic [PROD_W-1:0] p_prod;
    logic [ACC_W-1:0]  err_ext;
    logic [ACC_W-1:0]  acc_sum;
    logic              acc_ovf;
    logic              acc_clr;
    logic [DIFF_W-1:0] d_diff;
    logic [DSAT_W-1:0] d_sat;
    logic [PID_W-1:0]  pid;
    logic [SUM_W-1:0]  frwrd_ext;
    logic [SUM_W-1:0]  pid_ext;
    logic [SUM_W-1:0]  lft_sum;
    logic [SUM_W-1:0]  rght_sum;

    // Clamp the raw error into the signed SAT_W range.
    always_comb begin
        if (error[ERR_W-1:SAT_W-1] == {(ERR_W-SAT_W+1){error[ERR_W-1]}}) begin
            err_sat = error[SAT_W-1:0];
        end else if (error[ERR_W-1]) begin
            err_sat = {1'b1, {(SAT_W-1){1'b0}}};
        end else begin
            err_sat = {1'b0, {(SAT_W-1){1'b1}}};
        end
    end

    // P_term: full-width product, then clamp into P_W.
    always_comb begin
        p_prod = $signed({{(PROD_W-SAT_W){err_sat[SAT_W-1]}}, err_sat})
               * $signed({{(PROD_W-6){p_coeff[5]}}, p_coeff});
        if (p_prod[PROD_W-1:P_W-1] == {(PROD_W-P_W+1){p_prod[PROD_W-1]}}) begin
            p_term_d = p_prod[P_W-1:0];
        end else if (p_prod[PROD_W-1]) begin
            p_term_d = {1'b1, {(P_W-1){1'b0}}};
        end else begin
            p_term_d = {1'b0, {(P_W-1){1'b1}}};
        end
    end

    // Integrator: clear has priority; a would-be signed overflow holds the value and flags it.
    always_comb begin
        err_ext = {{(ACC_W-SAT_W){err_sat[SAT_W-1]}}, err_sat};
        acc_sum = acc_q + err_ext;
        acc_ovf = (acc_q[ACC_W-1] == err_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
        acc_clr = !go || !moving || (line_present && !line_q);
        acc_d    = acc_q;
        i_hold_d = i_hold_q;
        if (acc_clr) begin
            acc_d = '0;
            if (err_vld) begin
                i_hold_d = 1'b0;
            end
        end else if (err_vld) begin
            if (acc_ovf) begin
                i_hold_d = 1'b1;
            end else begin
                acc_d    = acc_sum;
                i_hold_d = 1'b0;
            end
        end
        // I_term sees the accumulator after this sample's update.
        i_term_d = acc_d[ACC_W-1:I_SHIFT];
    end

    // Error history shifts only on valid samples; entry D_DEPTH-1 is the oldest.
    always_comb begin
        hist_d = hist_q;
        if (err_vld) begin
            hist_d[0] = err_sat;
            for (int k = 1; k < D_DEPTH; k++) begin
                hist_d[k] = hist_q[k-1];
            end
        end
    end

    // D_term: difference against the oldest sample, clamped to 8 bits, then scaled.
    always_comb begin
        d_diff = {err_sat[SAT_W-1], err_sat}
               - {hist_q[D_DEPTH-1][SAT_W-1], hist_q[D_DEPTH-1]};
        if (d_diff[DIFF_W-1:DSAT_W-1] == {(DIFF_W-DSAT_W+1){d_diff[DIFF_W-1]}}) begin
            d_sat = d_diff[DSAT_W-1:0];
        end else if (d_diff[DIFF_W-1]) begin
            d_sat = {1'b1, {(DSAT_W-1){1'b0}}};
        end else begin
            d_sat = {1'b0, {(DSAT_W-1){1'b1}}};
        end
        d_term_d = $signed({{(D_W-DSAT_W){d_sat[DSAT_W-1]}}, d_sat})
                 * $signed({{(D_W-7){d_coeff[6]}}, d_coeff});
    end

    // Stage 1 captures the terms only for a valid sample, so coefficient changes elsewhere
    // have no effect.
    always_comb begin
        s1_vld_d = err_vld;
    end

    // Stage 2: combine terms, apply base speed and clamp; go=0 forces the speeds to zero.
    always_comb begin
        pid = {{(PID_W-P_W){p_term_q[P_W-1]}}, p_term_q}
            + {{(PID_W-I_W){i_term_q[I_W-1]}}, i_term_q}
            + {{(PID_W-D_W){d_term_q[D_W-1]}}, d_term_q};
        frwrd_ext = {{(SUM_W-SPD_W){frwrd[SPD_W-1]}}, frwrd};
        pid_ext   = {{(SUM_W-PID_W){pid[PID_W-1]}}, pid};
        lft_sum   = frwrd_ext + pid_ext;
        rght_sum  = frwrd_ext - pid_ext;
        lft_d     = lft_q;
        rght_d    = rght_q;
        spd_vld_d = s1_vld_q;
        if (s1_vld_q) begin
            if (go) begin
                lft_d  = sat_spd(lft_sum);
                rght_d = sat_spd(rght_sum);
            end else begin
                lft_d  = '0;
                rght_d = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Integrator, hold flag, line edge register and error history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            i_hold_q <= 1'b0;
            line_q   <= 1'b0;
            for (int k = 0; k < D_DEPTH; k++) begin
                hist_q[k] <= '0;
            end
        end else begin
            acc_q    <= acc_d;
            i_hold_q <= i_hold_d;
            line_q   <= line_present;
            hist_q   <= hist_d;
        end
    end

    // Stage 1 term registers, loaded only on valid samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            p_term_q <= '0;
            i_term_q <= '0;
            d_term_q <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            if (err_vld) begin
                p_term_q <= p_term_d;
                i_term_q <= i_term_d;
                d_term_q <= d_term_d;
            end
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_q     <= '0;
            rght_q    <= '0;
            spd_vld_q <= 1'b0;
        end else begin
            lft_q     <= lft_d;
            rght_q    <= rght_d;
            spd_vld_q <= spd_vld_d;
        end
    end

    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;
    assign spd_vld  = spd_vld_q;
    assign i_hold   = i_hold_q;

endmodule
